// File: rtl/prom_loader.sv
`default_nettype none
// ============================================================================
//  Module   : prom_loader
//  Purpose  : Download-able 256x4 nibble PROM. A byte stream (valid/ready)
//             is packed into a 128x8 RAM. The result is served through the
//             same registered 256x4 read port (a -> d, 1-cycle latency) as
//             the fixed PROMs.
//  Ports    : clk, reset (async, active-high)
//             start            - one-cycle pulse, begins a (re)load
//             in_data/in_valid/in_ready - byte stream handshake
//             busy             - load in progress
//             loaded           - image complete, read port live
//             load_err         - checksum failure (0 unless checksum built in)
//             a / d            - PROM read address / registered nibble data
//  Options  : `define PROM_LOADER_CHECKSUM_EN adds a trailing checksum byte.
//             The sum of all data bytes plus the checksum must be 0 mod 256.
//  Revision : 1.0 - initial release
// ============================================================================
module prom_loader #(
    parameter int NBYTES   = 128,
    parameter bit HI_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       busy,
    output logic       loaded,
    output logic       load_err,
    input  logic [7:0] a,
    output logic [3:0] d
);
    localparam int CW = $clog2(NBYTES);
    localparam logic [CW-1:0] c_LAST = CW'(NBYTES - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd3;
`ifdef PROM_LOADER_CHECKSUM_EN
    localparam logic [1:0] c_CHECK = 2'd2;
`endif

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_ram [NBYTES];
    logic          w_xfer;
    logic          w_wr;
    logic [7:0]    w_rbyte;

    // Only LOAD (and CHECK) accept bytes; everything else drops the stream.
    always_comb begin
        in_ready = (r_state == c_LOAD);
`ifdef PROM_LOADER_CHECKSUM_EN
        in_ready = in_ready | (r_state == c_CHECK);
`endif
    end

    assign busy   = in_ready;
    assign loaded = (r_state == c_DONE);
    assign w_xfer = in_valid & in_ready;
    assign w_wr   = w_xfer & (r_state == c_LOAD);

`ifdef PROM_LOADER_CHECKSUM_EN
    logic [7:0] r_sum;
    logic [7:0] w_sum_next;
    logic       r_err;

    assign w_sum_next = r_sum + in_data;
    assign load_err   = r_err;

    // Running sum of data bytes; the checksum byte is added in CHECK and
    // the 8-bit total must come out as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sum <= 8'd0;
            r_err <= 1'b0;
        end else begin
            if ((r_state == c_IDLE || r_state == c_DONE) && start) begin
                r_sum <= 8'd0;
                r_err <= 1'b0;
            end else if (w_wr) begin
                r_sum <= w_sum_next;
            end else if (r_state == c_CHECK && w_xfer && w_sum_next != 8'd0) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    assign load_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_state <= c_LOAD;
                        r_cnt   <= '0;
                    end
                end
                c_LOAD: begin
                    if (w_xfer) begin
                        // The last byte leaves LOAD instead of incrementing,
                        // so the counter never wraps.
                        if (r_cnt == c_LAST) begin
`ifdef PROM_LOADER_CHECKSUM_EN
                            r_state <= c_CHECK;
`else
                            r_state <= c_DONE;
`endif
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
`ifdef PROM_LOADER_CHECKSUM_EN
                c_CHECK: begin
                    if (w_xfer) begin
                        r_state <= (w_sum_next == 8'd0) ? c_DONE : c_IDLE;
                    end
                end
`endif
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Image storage: no reset so it maps onto block/distributed RAM.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_ram[r_cnt] <= in_data;
        end
    end

    assign w_rbyte = r_ram[a[CW:1]];

    // Reads return zero until an image is complete. Writes only happen
    // while loaded is low, so there is no read/write hazard.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d <= 4'h0;
        end else if (!loaded) begin
            d <= 4'h0;
        end else begin
            d <= (a[0] ^ HI_FIRST) ? w_rbyte[7:4] : w_rbyte[3:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prom_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prom_loader
//  Purpose  : Self-checking bench for prom_loader (HI_FIRST = 0). Reads are
//             scored through an expected-value queue drained by a monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prom_loader;
    localparam int NB = 128;
`ifdef PROM_LOADER_CHECKSUM_EN
    localparam int NSEND = NB + 1;
`else
    localparam int NSEND = NB;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       busy;
    logic       loaded;
    logic       load_err;
    logic [7:0] a;
    logic [3:0] d;

    prom_loader #(.NBYTES(NB), .HI_FIRST(1'b0)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .busy     (busy),
        .loaded   (loaded),
        .load_err (load_err),
        .a        (a),
        .d        (d)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] model_img [NB];
    bit         model_loaded = 1'b0;
    logic [7:0] stim [NSEND];
    logic [3:0] q_exp [$];
    string      q_name [$];
    bit         rd_req = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference PROM view: even address = low nibble of the byte at addr/2.
    function automatic logic [3:0] exp_nib(input logic [7:0] addr);
        logic [7:0] b;
        if (!model_loaded) return 4'h0;
        b = model_img[addr[7:1]];
        return addr[0] ? b[7:4] : b[3:0];
    endfunction

    // Monitor: a read sampled on a posedge shows its data right after it.
    initial begin
        forever begin
            @(posedge clk);
            if (rd_req) begin
                #1;
                if (q_exp.size() == 0) chk("rd_queue_underflow", 32'd1, 32'd0);
                else chk(q_name.pop_front(), {28'd0, d}, {28'd0, q_exp.pop_front()});
            end
        end
    end

    // All stimulus tasks start and end just after a negedge.
    task automatic rd(input logic [7:0] addr);
        a      = addr;
        rd_req = 1'b1;
        q_exp.push_back(exp_nib(addr));
        q_name.push_back($sformatf("rd_a%02h", addr));
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_loaded = 1'b0;
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_loaded_low", {31'd0, loaded}, 32'd0);
        chk("start_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    // mode 0: valid every cycle, 1: every other cycle, 2: random gaps.
    task automatic stream(input int mode, input bit mid_start, input int nsend);
        int idx = 0;
        int cyc = 0;
        bit acc;
        while (idx < nsend && cyc < 4000) begin
            in_data = stim[idx];
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (cyc % 2 == 0);
                default: in_valid = ($urandom_range(0, 3) != 0);
            endcase
            start = mid_start && (cyc == 60);
            acc   = in_valid && in_ready;
            if (acc && idx == nsend - 1) chk("loaded_before_last", {31'd0, loaded}, 32'd0);
            @(negedge clk);
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("stream_accepted", idx, nsend);
    endtask

    task automatic expect_done();
        chk("done_loaded", {31'd0, loaded}, 32'd1);
        chk("done_in_ready", {31'd0, in_ready}, 32'd0);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_load_err", {31'd0, load_err}, 32'd0);
        model_loaded = 1'b1;
        for (int i = 0; i < NB; i++) model_img[i] = stim[i];
    endtask

    task automatic set_csum();
`ifdef PROM_LOADER_CHECKSUM_EN
        logic [7:0] s = 8'd0;
        for (int i = 0; i < NB; i++) s = s + stim[i];
        stim[NB] = 8'd0 - s;
`endif
    endtask

    task automatic full_load(input int mode, input bit mid_start);
        set_csum();
        do_start();
        stream(mode, mid_start, NSEND);
        expect_done();
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        a        = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state and read before any load.
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_loaded", {31'd0, loaded}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_load_err", {31'd0, load_err}, 32'd0);
        rd(8'h5f);

        // Ramp image, back-to-back bytes.
        for (int i = 0; i < NB; i++) stim[i] = 8'(i);
        full_load(0, 1'b0);
        rd(8'h05); rd(8'h04); rd(8'hff); rd(8'h00); rd(8'h81);

        // Same image with in_valid toggling and a stray start mid-stream.
        do_start();
        rd(8'h10);
        set_csum();
        stream(1, 1'b1, NSEND);
        expect_done();
        rd(8'h05); rd(8'h04); rd(8'hff); rd(8'h3a);

        // Reset in the middle of a load.
        for (int i = 0; i < NB; i++) stim[i] = 8'($urandom);
        set_csum();
        do_start();
        stream(0, 1'b0, 40);
        #1 reset = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_loaded", {31'd0, loaded}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst_d", {28'd0, d}, 32'd0);
        model_loaded = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        rd(8'h02);
        full_load(2, 1'b0);
        for (int i = 0; i < 12; i++) rd(8'($urandom));

`ifdef PROM_LOADER_CHECKSUM_EN
        // Good checksum, then a bad one.
        for (int i = 0; i < NB; i++) stim[i] = 8'h01;
        stim[NB] = 8'h80;
        do_start();
        stream(0, 1'b0, NSEND);
        expect_done();
        rd(8'h00); rd(8'h01);
        stim[NB] = 8'h81;
        do_start();
        stream(0, 1'b0, NSEND);
        chk("bad_csum_loaded", {31'd0, loaded}, 32'd0);
        chk("bad_csum_err", {31'd0, load_err}, 32'd1);
        chk("bad_csum_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bad_csum_busy", {31'd0, busy}, 32'd0);
        rd(8'h00);
        do_start();
        chk("restart_clears_err", {31'd0, load_err}, 32'd0);
        stream(0, 1'b0, NSEND - 1);
        stim[NB] = 8'h80;
        in_data  = stim[NB];
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        expect_done();
        rd(8'h7e);
`endif

        // Reload with inverted data: reads are zero until it completes.
        for (int i = 0; i < NB; i++) stim[i] = ~8'(i);
        set_csum();
        do_start();
        rd(8'h00); rd(8'h33);
        stream(0, 1'b0, NSEND);
        expect_done();
        rd(8'h00); rd(8'h01); rd(8'hfe);

        // Random images with random gaps and random reads.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NB; i++) stim[i] = 8'($urandom);
            full_load(2, (r == 1));
            for (int i = 0; i < 20; i++) rd(8'($urandom));
        end

        repeat (3) @(negedge clk);
        chk("rd_queue_drained", q_exp.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
